// File: rtl/ram_master.sv
// ram_master: CPU-side initiator for a level-sensitive asynchronous RAM port.
// Serves READ, WRITE and ADD (read-modify-write) requests one at a time.
module ram_master #(
  parameter int unsigned addr_bits     = 16,
  parameter int unsigned data_bits     = 8,
  parameter int unsigned settle_cycles = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [addr_bits-1:0] req_address,
  input  logic [data_bits-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [data_bits-1:0] resp_data,
  output logic                 ram_write_enable,
  output logic [addr_bits-1:0] ram_address,
  output logic [data_bits-1:0] ram_data_in,
  input  logic [data_bits-1:0] ram_data_out
);

  localparam int unsigned CW =
    (settle_cycles > 1) ? $clog2(settle_cycles) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(settle_cycles - 1);

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    WR_SETUP,
    WR_STROBE,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 is_add_q, is_add_d;
  logic [data_bits-1:0] delta_q, delta_d;
  logic [addr_bits-1:0] addr_q, addr_d;
  logic [data_bits-1:0] din_q, din_d;
  logic                 we_q, we_d;
  logic                 rvalid_q, rvalid_d;
  logic [data_bits-1:0] rdata_q, rdata_d;

  // Ready only while idle and out of reset, so nothing is taken during reset.
  assign req_ready        = rst_n && (state_q == IDLE);
  assign resp_valid       = rvalid_q;
  assign resp_data        = rdata_q;
  assign ram_write_enable = we_q;
  assign ram_address      = addr_q;
  assign ram_data_in      = din_q;

  // Next-state and registered-output logic of the RAM sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_add_d = is_add_q;
    delta_d  = delta_q;
    addr_d   = addr_q;
    din_d    = din_q;
    we_d     = we_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_address;
          cnt_d    = '0;
          is_add_d = (req_op == OP_ADD);
          delta_d  = req_wdata;
          if (req_op == OP_WRITE) begin
            din_d   = req_wdata;
            state_d = WR_SETUP;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          if (is_add_q) begin
            din_d   = ram_data_out + delta_q;
            state_d = WR_SETUP;
          end else begin
            rdata_d  = ram_data_out;
            rvalid_d = 1'b1;
            state_d  = DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WR_SETUP: begin
        we_d    = 1'b1;
        cnt_d   = '0;
        state_d = WR_STROBE;
      end
      WR_STROBE: begin
        if (cnt_q == CNT_LAST) begin
          we_d     = 1'b0;
          rdata_d  = din_q;
          rvalid_d = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        we_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_add_q <= 1'b0;
      delta_q  <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      we_q     <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_add_q <= is_add_d;
      delta_q  <= delta_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      we_q     <= we_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master: scoreboard bench for ram_master, S=1 and S=3 instances.
// Each instance drives its own behavioural RAM.
module tb_ram_master;

  typedef struct {
    logic [7:0] data;
    logic [7:0] alt;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [1:0]  req_op [2];
  logic [15:0] req_addr [2];
  logic [7:0]  req_wdata [2];
  logic        resp_valid [2];
  logic [7:0]  resp_data [2];
  logic        ram_we [2];
  logic [15:0] ram_addr [2];
  logic [7:0]  ram_din [2];
  logic [7:0]  ram_dout [2];

  int chk = 0;
  int err = 0;
  int cyc = 0;
  int free_at [2];
  exp_t sb [2][$];
  int werise [2][$];
  logic [7:0] refm [2][65536];

  always #5 if (clk_en) clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int S = (g == 0) ? 1 : 3;
    logic [7:0]  mem [65536];
    logic        pwe;
    logic [15:0] pa;
    logic [7:0]  pd;
    int          width;
    int          e_cyc;
    exp_t        x;

    ram_master #(
      .addr_bits(16),
      .data_bits(8),
      .settle_cycles(S)
    ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_op(req_op[g]),
      .req_address(req_addr[g]),
      .req_wdata(req_wdata[g]),
      .resp_valid(resp_valid[g]),
      .resp_data(resp_data[g]),
      .ram_write_enable(ram_we[g]),
      .ram_address(ram_addr[g]),
      .ram_data_in(ram_din[g]),
      .ram_data_out(ram_dout[g])
    );

    initial for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    assign ram_dout[g] = mem[ram_addr[g]];
    always @(posedge clk) if (ram_we[g] === 1'b1) mem[ram_addr[g]] <= ram_din[g];

    // response monitor
    always @(negedge clk) begin
      if (rst_n === 1'b1 && resp_valid[g] === 1'b1) begin
        chk++;
        if (sb[g].size() == 0) begin
          err++;
          $display("FAIL resp_unexpected inst%0d cyc=%0d data=%h", g, cyc, resp_data[g]);
        end else begin
          x = sb[g].pop_front();
          if ($isunknown(resp_data[g]) ||
              (resp_data[g] !== x.data && resp_data[g] !== x.alt) ||
              cyc != x.cyc) begin
            err++;
            $display("FAIL resp inst%0d got data=%h cyc=%0d want data=%h/%h cyc=%0d",
                     g, resp_data[g], cyc, x.data, x.alt, x.cyc);
          end
        end
      end
    end

    // write strobe width, timing and address/data stability
    always @(negedge clk) begin
      if (rst_n !== 1'b1) begin
        pwe = 1'b0;
        width = 0;
      end else begin
        if (ram_we[g] === 1'b1) begin
          width++;
          chk++;
          if (ram_addr[g] !== pa || ram_din[g] !== pd) begin
            err++;
            $display("FAIL stable inst%0d cyc=%0d addr=%h/%h din=%h/%h",
                     g, cyc, ram_addr[g], pa, ram_din[g], pd);
          end
          if (!pwe) begin
            chk++;
            if (werise[g].size() == 0) begin
              err++;
              $display("FAIL we_unexpected inst%0d cyc=%0d", g, cyc);
            end else begin
              e_cyc = werise[g].pop_front();
              if (e_cyc != cyc) begin
                err++;
                $display("FAIL we_rise inst%0d got cyc=%0d want %0d", g, cyc, e_cyc);
              end
            end
          end
        end else if (pwe) begin
          chk++;
          if (width != S) begin
            err++;
            $display("FAIL we_width inst%0d got %0d want %0d", g, width, S);
          end
          width = 0;
        end
        pwe = ram_we[g];
        pa  = ram_addr[g];
        pd  = ram_din[g];
      end
    end
  end

  task automatic issue(input int i, input logic [1:0] op,
                       input logic [15:0] a, input logic [7:0] d);
    int s, n, lat;
    bit got;
    logic [7:0] e;
    s = (i == 0) ? 1 : 3;
    req_valid[i] = 1'b1;
    req_op[i]    = op;
    req_addr[i]  = a;
    req_wdata[i] = d;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      chk++;
      if (req_ready[i] !== (cyc >= free_at[i])) begin
        err++;
        $display("FAIL ready inst%0d cyc=%0d got %b want %b",
                 i, cyc, req_ready[i], cyc >= free_at[i]);
      end
      if (req_ready[i] === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      err++;
      $display("FAIL accept_timeout inst%0d got ready=%b want 1", i, req_ready[i]);
      req_valid[i] = 1'b0;
      return;
    end
    n = cyc + 1;
    case (op)
      2'b01: begin
        lat = s + 1;
        refm[i][a] = d;
        e = d;
        werise[i].push_back(n + 1);
      end
      2'b10: begin
        lat = 2 * s + 1;
        e = refm[i][a] + d;
        refm[i][a] = e;
        werise[i].push_back(n + s + 1);
      end
      default: begin
        lat = s;
        e = refm[i][a];
      end
    endcase
    sb[i].push_back('{data: e, alt: e, cyc: n + lat});
    free_at[i] = n + lat + 1;
    @(negedge clk);
  endtask

  task automatic gap(input int i);
    req_valid[i] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      if (sb[0].size() == 0 && sb[1].size() == 0 &&
          werise[0].size() == 0 && werise[1].size() == 0) done = 1'b1;
      else @(negedge clk);
    end
    chk++;
    if (!done) begin
      err++;
      $display("FAIL drain got pending=%0d want 0",
               sb[0].size() + sb[1].size() + werise[0].size() + werise[1].size());
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got time=%0t want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 65536; a++) refm[i][a] = 8'h00;
      req_valid[i] = 1'b0;
      req_op[i]    = 2'b00;
      req_addr[i]  = 16'h0;
      req_wdata[i] = 8'h0;
      free_at[i]   = 0;
    end
    rst_n = 1'b1;
    #5 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk++;
      if (req_ready[i] !== 1'b0 || resp_valid[i] !== 1'b0 || ram_we[i] !== 1'b0 ||
          ram_addr[i] !== 16'h0 || ram_din[i] !== 8'h0 || resp_data[i] !== 8'h0) begin
        err++;
        $display("FAIL reset_outputs inst%0d got rdy=%b rv=%b we=%b a=%h di=%h rd=%h want all 0",
                 i, req_ready[i], resp_valid[i], ram_we[i], ram_addr[i], ram_din[i], resp_data[i]);
      end
    end
    clk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk++;
      if (req_ready[i] !== 1'b1 || ram_we[i] !== 1'b0) begin
        err++;
        $display("FAIL post_reset inst%0d got rdy=%b we=%b want rdy=1 we=0",
                 i, req_ready[i], ram_we[i]);
      end
      free_at[i] = cyc;
    end
    @(negedge clk);

    // S=1 directed: write/read, ADD wrap both ways, reserved op
    issue(0, 2'b01, 16'h1234, 8'hA5); gap(0);
    issue(0, 2'b00, 16'h1234, 8'h00); gap(0);
    issue(0, 2'b01, 16'h0010, 8'hFF); gap(0);
    issue(0, 2'b10, 16'h0010, 8'h01); gap(0);
    issue(0, 2'b00, 16'h0010, 8'h00); gap(0);
    issue(0, 2'b10, 16'h0010, 8'hFF); gap(0);
    issue(0, 2'b00, 16'h0010, 8'h00); gap(0);
    issue(0, 2'b11, 16'h1234, 8'h77); gap(0);
    issue(0, 2'b00, 16'h1234, 8'h00); gap(0);

    // five requests with req_valid held high
    issue(0, 2'b01, 16'h0020, 8'h11);
    issue(0, 2'b01, 16'h0021, 8'h22);
    issue(0, 2'b10, 16'h0020, 8'hF0);
    issue(0, 2'b00, 16'h0021, 8'h00);
    issue(0, 2'b00, 16'h0020, 8'h00);
    gap(0);

    // S=3: ADD wrap then random back-to-back mix
    issue(1, 2'b01, 16'h0010, 8'hFF);
    issue(1, 2'b10, 16'h0010, 8'h01);
    issue(1, 2'b10, 16'h0010, 8'hFF);
    for (int k = 0; k < 24; k++) begin
      logic [1:0]  op;
      logic [15:0] a;
      logic [7:0]  d;
      op = 2'($urandom_range(0, 3));
      a  = 16'h0100 + 16'($urandom_range(0, 7));
      d  = 8'($urandom);
      issue(1, op, a, d);
    end
    gap(1);
    drain();
    for (int a = 16'h0100; a < 16'h0108; a++) begin
      chk++;
      if (g_dut[1].mem[a] !== refm[1][a]) begin
        err++;
        $display("FAIL mem inst1 addr=%h got %h want %h", a, g_dut[1].mem[a], refm[1][a]);
      end
    end

    // reset in the middle of a write strobe
    issue(0, 2'b01, 16'h0040, 8'h5A);
    req_valid[0] = 1'b0;
    for (int k = 0; k < 10 && ram_we[0] !== 1'b1; k++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      sb[i].delete();
      werise[i].delete();
    end
    chk++;
    if (ram_we[0] !== 1'b0 || resp_valid[0] !== 1'b0) begin
      err++;
      $display("FAIL abort got we=%b rv=%b want 0 0", ram_we[0], resp_valid[0]);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    free_at[0] = cyc;
    free_at[1] = cyc;
    repeat (2) @(negedge clk);
    issue(0, 2'b00, 16'h0040, 8'h00);
    sb[0][sb[0].size() - 1].alt = 8'h00;
    gap(0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
